// File: rtl/game_timer.sv
// Countdown timer with prescaled tick qualification, pause, one-shot/periodic
// modes and a registered one-cycle expiry pulse.
module game_timer #(
  parameter int               WIDTH    = 7,
  parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b1}},
  parameter int               PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_start,
  input  logic             timer_tick,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             timer_up,
  output logic             timer_done
);

  typedef enum logic {RUN = 1'b0, EXPIRED = 1'b1} state_t;

  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_count,  w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic [PW-1:0]    r_presc,  w_presc_nxt;
  logic             r_done,   w_done_nxt;
  logic             w_qtick;
  logic             w_dec;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_count  <= INIT_VAL;
      r_reload <= INIT_VAL;
      r_presc  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_presc  <= w_presc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state logic; timer_start outranks ticks, pause and expiry
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_presc_nxt  = r_presc;
    w_done_nxt   = 1'b0;
    w_qtick      = timer_tick & ~pause & (r_state == RUN);
    w_dec        = w_qtick & (r_presc == PRESC_MAX);

    if (timer_start) begin
      w_reload_nxt = load_val;
      w_count_nxt  = load_val;
      w_presc_nxt  = '0;
      w_state_nxt  = (load_val == '0) ? EXPIRED : RUN;
    end else if (w_qtick) begin
      w_presc_nxt = w_dec ? '0 : r_presc + PW'(1);
      if (w_dec) begin
        if (r_count > ONE) begin
          w_count_nxt = r_count - ONE;
        end else if (r_count == ONE) begin
          w_done_nxt = 1'b1;
          if (auto_reload && (r_reload != '0)) begin
            w_count_nxt = r_reload;
          end else begin
            w_count_nxt = '0;
            w_state_nxt = EXPIRED;
          end
        end else begin
          // Running at zero (only reachable with INIT_VAL == 0): park silently
          w_state_nxt = EXPIRED;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    count      = r_count;
    timer_up   = (r_count == '0);
    timer_done = r_done;
  end

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: a default instance and a PRESCALE=4 instance
// share stimulus; expected outputs are queued per cycle and popped after the edge.
module tb_game_timer;

  logic       clk;
  logic       reset;
  logic       timer_start;
  logic       timer_tick;
  logic       pause;
  logic       auto_reload;
  logic [6:0] load_val;
  logic [6:0] count_a, count_b;
  logic       up_a, up_b, done_a, done_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       rs, st, tk, ps, ar;
    logic [6:0] lv;
    logic [6:0] cnt;
    logic       up, dn;
  } step_t;

  typedef struct packed {
    logic [6:0] cnt;
    logic       up, dn;
  } exp_t;

  exp_t q[$];

  game_timer #(.WIDTH(7), .INIT_VAL(7'h7F), .PRESCALE(1)) u_dut_a (
    .clk(clk), .reset(reset), .timer_start(timer_start), .timer_tick(timer_tick),
    .pause(pause), .auto_reload(auto_reload), .load_val(load_val),
    .count(count_a), .timer_up(up_a), .timer_done(done_a)
  );

  game_timer #(.WIDTH(7), .INIT_VAL(7'h7F), .PRESCALE(4)) u_dut_b (
    .clk(clk), .reset(reset), .timer_start(timer_start), .timer_tick(timer_tick),
    .pause(pause), .auto_reload(auto_reload), .load_val(load_val),
    .count(count_b), .timer_up(up_b), .timer_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(logic rs, logic st, logic tk, logic ps, logic ar,
                               logic [6:0] lv, logic [6:0] cnt, logic up, logic dn);
    step_t s;
    s.rs = rs; s.st = st; s.tk = tk; s.ps = ps; s.ar = ar;
    s.lv = lv; s.cnt = cnt; s.up = up; s.dn = dn;
    return s;
  endfunction

  // Apply one cycle of stimulus and queue what the outputs must be after the edge
  task automatic drive(input step_t s);
    exp_t e;
    reset       = s.rs;
    timer_start = s.st;
    timer_tick  = s.tk;
    pause       = s.ps;
    auto_reload = s.ar;
    load_val    = s.lv;
    e.cnt = s.cnt; e.up = s.up; e.dn = s.dn;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; timer_start = 1'b0; timer_tick = 1'b0;
    pause = 1'b0; auto_reload = 1'b0; load_val = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(mk(1, 1, 1, 0, 0, 7'd3, 7'd127, 0, 0));
    @(posedge clk); #1;
    e = q.pop_front();
    n_checks++; if (count_a !== e.cnt) $display("FAIL reset count_a got %0d want %0d", count_a, e.cnt); else n_pass++;
    n_checks++; if (up_a    !== e.up)  $display("FAIL reset up_a got %b want %b", up_a, e.up); else n_pass++;
    n_checks++; if (done_a  !== e.dn)  $display("FAIL reset done_a got %b want %b", done_a, e.dn); else n_pass++;
    n_checks++; if (count_b !== e.cnt) $display("FAIL reset count_b got %0d want %0d", count_b, e.cnt); else n_pass++;
    n_checks++; if (done_b  !== e.dn)  $display("FAIL reset done_b got %b want %b", done_b, e.dn); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_oneshot();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 1, 0, 0, 0, 7'd3, 7'd3, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 1));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 7'd0, 7'd0, 1, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++; if (count_a !== e.cnt) $display("FAIL oneshot[%0d] count got %0d want %0d", i, count_a, e.cnt); else n_pass++;
      n_checks++; if (up_a    !== e.up)  $display("FAIL oneshot[%0d] timer_up got %b want %b", i, up_a, e.up); else n_pass++;
      n_checks++; if (done_a  !== e.dn)  $display("FAIL oneshot[%0d] timer_done got %b want %b", i, done_a, e.dn); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_periodic();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 1, 0, 0, 1, 7'd2, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd2, 0, 1));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd2, 0, 1));
    s.push_back(mk(0, 0, 0, 0, 1, 7'd0, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd2, 0, 1));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++; if (count_a !== e.cnt) $display("FAIL periodic[%0d] count got %0d want %0d", i, count_a, e.cnt); else n_pass++;
      n_checks++; if (up_a    !== e.up)  $display("FAIL periodic[%0d] timer_up got %b want %b", i, up_a, e.up); else n_pass++;
      n_checks++; if (done_a  !== e.dn)  $display("FAIL periodic[%0d] timer_done got %b want %b", i, done_a, e.dn); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_prescale();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 1, 0, 0, 0, 7'd2, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 1));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++; if (count_b !== e.cnt) $display("FAIL prescale[%0d] count got %0d want %0d", i, count_b, e.cnt); else n_pass++;
      n_checks++; if (up_b    !== e.up)  $display("FAIL prescale[%0d] timer_up got %b want %b", i, up_b, e.up); else n_pass++;
      n_checks++; if (done_b  !== e.dn)  $display("FAIL prescale[%0d] timer_done got %b want %b", i, done_b, e.dn); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 1, 0, 0, 0, 7'd1, 7'd1, 0, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 7'd5, 7'd5, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 7'd0, 7'd5, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 7'd0, 7'd0, 1, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 0));
    // auto_reload only matters at the count==1 decrement
    s.push_back(mk(0, 1, 0, 0, 0, 7'd2, 7'd2, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 7'd0, 7'd2, 0, 1));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 1));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++; if (count_a !== e.cnt) $display("FAIL collision[%0d] count got %0d want %0d", i, count_a, e.cnt); else n_pass++;
      n_checks++; if (up_a    !== e.up)  $display("FAIL collision[%0d] timer_up got %b want %b", i, up_a, e.up); else n_pass++;
      n_checks++; if (done_a  !== e.dn)  $display("FAIL collision[%0d] timer_done got %b want %b", i, done_a, e.dn); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 1, 0, 0, 0, 7'd6, 7'd6, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd5, 0, 0));
    s.push_back(mk(1, 1, 1, 0, 0, 7'd3, 7'd127, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 7'd0, 7'd127, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 7'd1, 7'd1, 0, 0));
    s.push_back(mk(1, 0, 1, 0, 0, 7'd0, 7'd127, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 7'd0, 7'd127, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 7'd1, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 7'd0, 7'd127, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++; if (count_a !== e.cnt) $display("FAIL reset_mid[%0d] count got %0d want %0d", i, count_a, e.cnt); else n_pass++;
      n_checks++; if (up_a    !== e.up)  $display("FAIL reset_mid[%0d] timer_up got %b want %b", i, up_a, e.up); else n_pass++;
      n_checks++; if (done_a  !== e.dn)  $display("FAIL reset_mid[%0d] timer_done got %b want %b", i, done_a, e.dn); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 1, 0, 0, 0, 7'd1, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 7'd1, 7'd1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 1));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd0, 1, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 7'd127, 7'd127, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 7'd0, 7'd126, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++; if (count_a !== e.cnt) $display("FAIL back_to_back[%0d] count got %0d want %0d", i, count_a, e.cnt); else n_pass++;
      n_checks++; if (up_a    !== e.up)  $display("FAIL back_to_back[%0d] timer_up got %b want %b", i, up_a, e.up); else n_pass++;
      n_checks++; if (done_a  !== e.dn)  $display("FAIL back_to_back[%0d] timer_done got %b want %b", i, done_a, e.dn); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_prescale();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (q.size() != 0) $display("FAIL scoreboard leftover entries got %0d want 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 7, counter width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter INIT_VAL, default {WIDTH{1'b1}}, count and reload value after reset.
REQ-003 SHALL have parameter PRESCALE, default 1, qualified ticks per decrement (PRESCALE >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port timer_start  input  1  load load_val and restart countdown.
REQ-007 SHALL have port timer_tick  input  1  time-base strobe, one cycle per tick.
REQ-008 SHALL have port pause  input  1  level; while high, ticks are ignored.
REQ-009 SHALL have port auto_reload  input  1  level; 1 = periodic mode, 0 = one-shot mode.
REQ-010 SHALL have port load_val  input  WIDTH  start/reload value, sampled on timer_start.
REQ-011 SHALL have port count  output  WIDTH  current count register.
REQ-012 SHALL have port timer_up  output  1  level, high while count == 0.
REQ-013 SHALL have port timer_done  output  1  registered one-cycle expiry pulse.

Function
REQ-014 SHALL implement state machine RUN / EXPIRED; RUN = counting, EXPIRED = count held at 0.
REQ-015 SHALL keep register reload_reg (WIDTH), loaded from load_val on every timer_start.
REQ-016 SHALL define qualified tick = timer_tick & ~pause & (state == RUN).
REQ-017 SHALL keep prescaler 0..PRESCALE-1, incrementing per qualified tick, wrapping to 0; a decrement event occurs on a qualified tick when prescaler == PRESCALE-1.
REQ-018 SHALL, with PRESCALE == 1, make every qualified tick a decrement event.
REQ-019 SHALL give timer_start priority over ticks, pause and expiry: next count = load_val, prescaler = 0, state = RUN; load_val == 0 instead gives count 0, state EXPIRED, no timer_done.
REQ-020 SHALL, on a decrement event with count > 1, set count = count - 1.
REQ-021 SHALL, on a decrement event with count == 1 and auto_reload == 0, set count = 0, state EXPIRED, timer_done = 1 next cycle.
REQ-022 SHALL, on a decrement event with count == 1 and auto_reload == 1, set count = reload_reg (stay RUN), timer_done = 1 next cycle; reload_reg == 0 gives count 0, state EXPIRED.
REQ-023 SHALL never decrement below 0; in EXPIRED, ticks change neither count nor prescaler.
REQ-024 SHALL sample auto_reload only at the count == 1 decrement event; changing it mid-count has no other effect.
REQ-025 SHALL hold count and prescaler unchanged while pause is high; on release, counting resumes from the held prescaler phase.
REQ-026 SHALL drive timer_done high for exactly one cycle per expiry, the same cycle count first shows the post-expiry value; 0 otherwise.
REQ-027 SHALL make timer_up purely combinational from count (count == 0), with no extra latency.
REQ-028 SHALL, with all defaults, auto_reload = 0 and load_val = all ones, match the legacy 7-bit countdown timer cycle for cycle.

Reset
REQ-029 SHALL, when reset is high at a rising clk edge, set count = INIT_VAL, reload_reg = INIT_VAL, prescaler = 0, state = RUN, timer_done = 0; reset overrides timer_start and ticks.
REQ-030 SHALL, on reset mid-count or mid-pulse, abandon the operation; timer_done is 0 the following cycle.

Verification
REQ-031 SHALL cover one-shot: WIDTH=7, PRESCALE=1, start with load_val=3, 3 ticks -> count 2,1,0; timer_done pulses 1 cycle with count==0; timer_up stays 1; further ticks keep 0.
REQ-032 SHALL cover periodic: load_val=2, auto_reload=1, 6 ticks -> count 1,2,1,2,1,2; timer_done pulses on the 2nd, 4th and 6th tick; timer_up never 1.
REQ-033 SHALL cover prescale: PRESCALE=4, load_val=2 -> count 1 after 4th tick, 0 after 8th; pause high across ticks 5-6 -> expiry after 10th tick.
REQ-034 SHALL cover collisions: timer_start together with the expiring tick -> count = load_val, no timer_done; start with load_val=0 -> timer_up=1, timer_done=0.
REQ-035 SHALL cover reset: reset asserted mid-count at count=5 together with timer_start -> next cycle count = INIT_VAL (127), timer_done = 0, timer_up = 0.
